// File: rtl/dcmi_ahb_wr_pkg.sv
// Shared AHB encodings, FSM state type and the FIFO entry layout for the DCMI RAM-to-AHB write stage.
package dcmi_ahb_wr_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } ahb_state_e;

  // Word address only; the byte offset bits never reach the FIFO.
  typedef struct packed {
    logic [21:0] waddr;
    logic [31:0] wdata;
  } wr_entry_t;

  function automatic logic [31:0] ahb_addr(input logic [31:0] base, input logic [21:0] word_addr);
    return base | {8'h00, word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/dcmi_ahb_wr_if.sv
// AHB-Lite master-side signal bundle used by the DCMI write stage.
interface dcmi_ahb_wr_if;

  // A transfer's address phase completes on the edge where htrans=NONSEQ and hready=1;
  // its data phase completes on the next edge with hready=1, hresp qualifying that edge.
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hready, hresp
  );

endinterface

// File: rtl/dcmi_ahb_wr_wfifo.sv
// Small synchronous FIFO of pending RAM writes with flush and a peek at the entry behind the head.
module dcmi_ahb_wr_wfifo
  import dcmi_ahb_wr_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned LW    = PW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  wr_entry_t     entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output wr_entry_t     head_o,
  output wr_entry_t     head_nxt_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  wr_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [LW-1:0] level_q;
  logic          push_ok, pop_ok;

  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign push_ok    = push_i & ~full_o & ~flush_i;
  assign pop_ok     = pop_i & ~empty_o & ~flush_i;
  assign rd_ptr_nxt = rd_ptr_q + PW'(1);
  assign head_o     = mem_q[rd_ptr_q];
  assign head_nxt_o = mem_q[rd_ptr_nxt];
  assign level_o    = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry_i;
  end

  // Flush only rewinds pointers and level; stale storage is unreachable afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_nxt;
      if (push_ok && !pop_ok)      level_q <= level_q + LW'(1);
      else if (pop_ok && !push_ok) level_q <= level_q - LW'(1);
    end
  end

endmodule

// File: rtl/dcmi_ahb_wr.sv
// Buffers single-word RAM writes and issues each one as a non-overlapped AHB-Lite SINGLE word write.
module dcmi_ahb_wr
  import dcmi_ahb_wr_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 4,
  parameter  logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter  logic [3:0]  HPROT_VAL  = 4'b0011,
  localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            hclk,
  input  logic            rstn,
  input  logic            enable,
  input  logic            ram_wr_req,
  output logic            ram_wr_ack,
  input  logic [23:0]     ram_waddr,
  input  logic [31:0]     ram_wdata,
  dcmi_ahb_wr_if.master   ahb,
  output logic            busy,
  output logic [LW-1:0]   fifo_level,
  output logic            err_pulse,
  output ahb_state_e      dbg_state
);

  ahb_state_e  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic        ack_q;
  logic        err_q, err_d;
  logic        push, pop, flush, full, empty;
  wr_entry_t   entry, head, head_nxt;
  logic        unused_bits;

  assign unused_bits = ^{ram_waddr[1:0], head_nxt.wdata};

  // ack_q in the guard stops the same held request from being captured twice.
  assign push  = enable & ram_wr_req & ~ack_q & ~full;
  assign flush = ~enable & (state_q == ST_IDLE);
  assign entry = '{waddr: ram_waddr[23:2], wdata: ram_wdata};

  dcmi_ahb_wr_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
    .clk       (hclk),
    .rstn      (rstn),
    .push_i    (push),
    .entry_i   (entry),
    .pop_i     (pop),
    .flush_i   (flush),
    .head_o    (head),
    .head_nxt_o(head_nxt),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    err_d    = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && !empty) begin
          state_d  = ST_ADDR;
          haddr_d  = ahb_addr(BASE_ADDR, head.waddr);
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = 1'b1;
        end
      end
      ST_ADDR: begin
        if (ahb.hready) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          hwrite_d = 1'b0;
          hwdata_d = head.wdata;
        end
      end
      ST_DATA: begin
        // A word pushed on this same edge is picked up from IDLE one cycle later.
        if (ahb.hready) begin
          pop   = 1'b1;
          err_d = ahb.hresp;
          if (enable && (fifo_level > LW'(1))) begin
            state_d  = ST_ADDR;
            haddr_d  = ahb_addr(BASE_ADDR, head_nxt.waddr);
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      ack_q    <= push;
      err_q    <= err_d;
    end
  end

  assign ram_wr_ack = ack_q;
  assign err_pulse  = err_q;
  assign busy       = (fifo_level != '0) || (state_q != ST_IDLE);
  assign dbg_state  = state_q;

  assign ahb.haddr  = haddr_q;
  assign ahb.htrans = htrans_q;
  assign ahb.hwrite = hwrite_q;
  assign ahb.hsize  = HSIZE_WORD;
  assign ahb.hburst = HBURST_SINGLE;
  assign ahb.hprot  = HPROT_VAL;
  assign ahb.hwdata = hwdata_q;

endmodule

// File: tb/tb_dcmi_ahb_wr.sv
// Directed bench for dcmi_ahb_wr: RAM-side driver, AHB slave model, scoreboard monitor on the AHB side.
`timescale 1ns/1ps
module tb_dcmi_ahb_wr;
  import dcmi_ahb_wr_pkg::*;

  localparam int DEPTH = 4;

  // clock / reset
  logic        hclk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        ram_wr_req = 1'b0;
  logic        ram_wr_ack;
  logic [23:0] ram_waddr = '0;
  logic [31:0] ram_wdata = '0;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        err_pulse;
  ahb_state_e  dbg_state;

  always #5 hclk = ~hclk;

  dcmi_ahb_wr_if ahb();

  dcmi_ahb_wr #(
    .FIFO_DEPTH(DEPTH),
    .BASE_ADDR (32'h2000_0000),
    .HPROT_VAL (4'b0011)
  ) dut (
    .hclk      (hclk),
    .rstn      (rstn),
    .enable    (enable),
    .ram_wr_req(ram_wr_req),
    .ram_wr_ack(ram_wr_ack),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ahb       (ahb),
    .busy      (busy),
    .fifo_level(fifo_level),
    .err_pulse (err_pulse),
    .dbg_state (dbg_state)
  );

  // scoreboard state: {err, haddr, hwdata}
  logic [64:0] exp_q[$];
  int vec_cnt = 0;
  int mis_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // AHB slave model, decisions made just after each rising edge
  int addr_waits = 0;
  int err_idx = -1;
  int xfer_idx = 0;

  initial begin
    int  wcnt;
    bit  sl_data;
    bit  sl_err_wait;
    wcnt = -1;
    sl_data = 1'b0;
    sl_err_wait = 1'b0;
    ahb.hready = 1'b1;
    ahb.hresp = 1'b0;
    forever begin
      @(posedge hclk);
      #1;
      if (!rstn) begin
        sl_data = 1'b0;
        sl_err_wait = 1'b0;
        wcnt = -1;
        ahb.hready = 1'b1;
        ahb.hresp = 1'b0;
      end else if (sl_data) begin
        if (xfer_idx == err_idx && !sl_err_wait) begin
          ahb.hready = 1'b0;
          ahb.hresp = 1'b1;
          sl_err_wait = 1'b1;
        end else begin
          ahb.hready = 1'b1;
          ahb.hresp = (xfer_idx == err_idx);
          sl_err_wait = 1'b0;
          sl_data = 1'b0;
          xfer_idx++;
        end
      end else if (ahb.htrans == HTRANS_NONSEQ) begin
        ahb.hresp = 1'b0;
        if (wcnt < 0) wcnt = addr_waits;
        if (wcnt > 0) begin
          ahb.hready = 1'b0;
          wcnt--;
        end else begin
          ahb.hready = 1'b1;
          wcnt = -1;
          sl_data = 1'b1;
        end
      end else begin
        ahb.hready = 1'b1;
        ahb.hresp = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard on each accepted address phase, checks the data phase
  logic [64:0] cur = '0;
  bit          mon_data = 1'b0;
  bit          err_due = 1'b0;
  int          err_seen = 0;
  int          nonseq_cycles = 0;
  int          max_level = 0;
  int          ack_full_viol = 0;
  logic [2:0]  prev_level = '0;

  always @(negedge hclk) begin
    if (!rstn) begin
      mon_data = 1'b0;
      err_due = 1'b0;
      prev_level = '0;
    end else begin
      if (err_pulse || err_due) check("err_pulse", 64'(err_pulse), 64'(err_due));
      if (err_pulse) err_seen++;
      err_due = 1'b0;
      if (ram_wr_ack && prev_level == 3'(DEPTH)) ack_full_viol++;
      prev_level = fifo_level;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (ahb.htrans == HTRANS_NONSEQ) nonseq_cycles++;
      if (mon_data) begin
        if (ahb.hready) begin
          check("hwdata", 64'(ahb.hwdata), 64'(cur[31:0]));
          check("hresp", 64'(ahb.hresp), 64'(cur[64]));
          err_due = cur[64];
          mon_data = 1'b0;
        end
      end else if (ahb.htrans == HTRANS_NONSEQ && ahb.hready) begin
        if (exp_q.size() == 0) begin
          vec_cnt++;
          mis_cnt++;
          $display("FAIL stray_xfer: haddr %0h issued, expected no transfer", ahb.haddr);
        end else begin
          cur = exp_q.pop_front();
          check("haddr", 64'(ahb.haddr), 64'(cur[63:32]));
          check("hwrite", 64'(ahb.hwrite), 64'(1));
          mon_data = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic write_word(input logic [23:0] a, input logic [31:0] d, input logic [31:0] exp_addr,
                            input bit exp_err, input bit expect_out, output int lat);
    int n;
    n = 0;
    ram_waddr = a;
    ram_wdata = d;
    ram_wr_req = 1'b1;
    if (expect_out) exp_q.push_back({exp_err, exp_addr, d});
    do begin
      @(negedge hclk);
      n++;
    end while (!ram_wr_ack && n < 200);
    if (!ram_wr_ack) begin
      vec_cnt++;
      mis_cnt++;
      $display("FAIL ack_timeout: no ack for waddr %0h after %0d cycles, expected an ack", a, n);
    end
    lat = n;
    ram_wr_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || mon_data || exp_q.size() != 0) && n < 500) begin
      @(negedge hclk);
      n++;
    end
    vec_cnt++;
    if (busy || mon_data || exp_q.size() != 0) begin
      mis_cnt++;
      $display("FAIL %s_drain: busy=%0b pending=%0d after %0d cycles, expected idle", name, busy, exp_q.size(), n);
    end
    @(negedge hclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int e0;
    int n0;
    int n;
    int acks;

    // reset values
    repeat (3) @(negedge hclk);
    check("rst_haddr_hwdata", {ahb.haddr, ahb.hwdata}, 64'h0);
    check("rst_ctl", 64'({ram_wr_ack, ahb.htrans, ahb.hwrite, busy, fifo_level, err_pulse, dbg_state}), 64'h0);
    rstn = 1'b1;
    enable = 1'b1;
    @(negedge hclk);
    check("const_hsize_hburst_hprot", 64'({ahb.hsize, ahb.hburst, ahb.hprot}), 64'({3'b010, 3'b000, 4'b0011}));
    check("idle_after_release", 64'({busy, fifo_level, ahb.htrans}), 64'h0);

    // 1: single write
    addr_waits = 0;
    n0 = nonseq_cycles;
    write_word(24'h000104, 32'hDEAD_BEEF, 32'h2000_0104, 1'b0, 1'b1, lat);
    check("t1_ack_latency", 64'(lat), 64'(1));
    wait_idle("t1");
    check("t1_nonseq_cycles", 64'(nonseq_cycles - n0), 64'(1));

    // 2: eight back-to-back words, three address wait states each
    addr_waits = 3;
    for (int i = 0; i < 8; i++) begin
      write_word(24'h000200 + 24'(i * 4), 32'h1000_0000 + 32'(i), 32'h2000_0200 + 32'(i * 4), 1'b0, 1'b1, lat);
    end
    wait_idle("t2");
    check("t2_max_level", 64'(max_level), 64'(DEPTH));
    check("t2_ack_while_full", 64'(ack_full_viol), 64'(0));

    // 3: error response on the second of three words
    addr_waits = 1;
    e0 = err_seen;
    err_idx = xfer_idx + 1;
    write_word(24'h000300, 32'hA1A1_0001, 32'h2000_0300, 1'b0, 1'b1, lat);
    write_word(24'h000304, 32'hB2B2_0002, 32'h2000_0304, 1'b1, 1'b1, lat);
    write_word(24'h000308, 32'hC3C3_0003, 32'h2000_0308, 1'b0, 1'b1, lat);
    wait_idle("t3");
    check("t3_err_pulses", 64'(err_seen - e0), 64'(1));
    check("t3_busy", 64'(busy), 64'(0));
    err_idx = -1;

    // 4: disable with three words queued while the first is in its address phase
    addr_waits = 6;
    write_word(24'h000400, 32'h4444_0001, 32'h2000_0400, 1'b0, 1'b1, lat);
    write_word(24'h000404, 32'h4444_0002, 32'h2000_0404, 1'b0, 1'b0, lat);
    write_word(24'h000408, 32'h4444_0003, 32'h2000_0408, 1'b0, 1'b0, lat);
    n = 0;
    while (ahb.htrans != HTRANS_NONSEQ && n < 50) begin
      @(negedge hclk);
      n++;
    end
    check("t4_in_addr", 64'(dbg_state), 64'(ST_ADDR));
    enable = 1'b0;
    ram_waddr = 24'h000500;
    ram_wdata = 32'h5000_0000;
    ram_wr_req = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge hclk);
      if (ram_wr_ack) acks++;
    end
    ram_wr_req = 1'b0;
    check("t4_ack_disabled", 64'(acks), 64'(0));
    check("t4_level", 64'(fifo_level), 64'(0));
    check("t4_busy", 64'(busy), 64'(0));
    check("t4_first_done", 64'(exp_q.size()), 64'(0));
    enable = 1'b1;
    repeat (3) @(negedge hclk);
    check("t4_resume_empty", 64'({busy, fifo_level}), 64'(0));

    // 5: asynchronous reset during a data phase
    addr_waits = 0;
    write_word(24'h000600, 32'h5555_0001, 32'h2000_0600, 1'b0, 1'b1, lat);
    write_word(24'h000604, 32'h5555_0002, 32'h2000_0604, 1'b0, 1'b0, lat);
    n = 0;
    while (dbg_state != ST_DATA && n < 50) begin
      @(negedge hclk);
      n++;
    end
    #2;
    rstn = 1'b0;
    #1;
    check("t5_rst_trans", 64'({ahb.htrans, ahb.hwrite}), 64'(0));
    check("t5_rst_level", 64'(fifo_level), 64'(0));
    check("t5_rst_busy_ack", 64'({busy, ram_wr_ack}), 64'(0));
    check("t5_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge hclk);
    @(negedge hclk);
    rstn = 1'b1;
    write_word(24'h000104, 32'h0BAD_F00D, 32'h2000_0104, 1'b0, 1'b1, lat);
    check("t5_ack_latency", 64'(lat), 64'(1));
    wait_idle("t5");

    // 6: unaligned and top-of-range addresses
    write_word(24'h000107, 32'hCAFE_F00D, 32'h2000_0104, 1'b0, 1'b1, lat);
    write_word(24'hFFFFFF, 32'h0123_4567, 32'h20FF_FFFC, 1'b0, 1'b1, lat);
    wait_idle("t6");

    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
